// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS waitrequest-style bus master.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_t;

   typedef enum logic [1:0] {
      BS_IDLE     = 2'd0,
      BS_BUS      = 2'd1,
      BS_RDATA    = 2'd2,
      BS_RESP_ERR = 2'd3
   } bus_state_t;

   localparam logic [31:0] RAM_BASE = 32'hBFC00000;

endpackage

// File: rtl/mips_bus_lane_align.sv
// Combinational byte-lane mapping: byteenable/writedata for stores, shift and
// extension for loads, and legality of the size/offset pair.
module mips_bus_lane_align (
   input  logic [1:0]  size,
   input  logic [1:0]  lo,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   output logic [31:0] rdata_fmt,
   output logic        misaligned
);
   import mips_bus_pkg::*;

   logic [31:0] shifted;

   assign shifted = rdata_raw >> {lo, 3'b000};

   always_comb begin
      byteenable = 4'b0000;
      writedata  = 32'h0;
      rdata_fmt  = 32'h0;
      misaligned = 1'b0;
      case (size)
         SIZE_BYTE: begin
            byteenable = 4'b0001 << lo;
            writedata  = {4{wdata[7:0]}};
            rdata_fmt  = sign_ext ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
         end
         SIZE_HALF: begin
            byteenable = lo[1] ? 4'b1100 : 4'b0011;
            writedata  = {2{wdata[15:0]}};
            rdata_fmt  = sign_ext ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
            misaligned = lo[0];
         end
         SIZE_WORD: begin
            byteenable = 4'b1111;
            writedata  = wdata;
            rdata_fmt  = shifted;
            misaligned = |lo;
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_bus_master.sv
// CPU-side initiator for the waitrequest memory bus: one load/store at a time.
// Optional stall abort is enabled by defining MIPS_BUS_MASTER_TIMEOUT_EN.
module mips_bus_master #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);
   import mips_bus_pkg::*;

   // state      | meaning
   // S_IDLE     | ready for a CPU request
   // S_BUS      | command on the bus, held until waitrequest is low
   // S_RDATA    | readdata valid, format and respond
   // S_RESP_ERR | error response cycle
   localparam logic [1:0] S_IDLE     = BS_IDLE;
   localparam logic [1:0] S_BUS      = BS_BUS;
   localparam logic [1:0] S_RDATA    = BS_RDATA;
   localparam logic [1:0] S_RESP_ERR = BS_RESP_ERR;

   logic [1:0]  state;
   logic [1:0]  lat_size;
   logic [1:0]  lat_lo;
   logic        lat_signed;
   logic [1:0]  al_size;
   logic [1:0]  al_lo;
   logic        al_signed;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_misaligned;
   logic        timeout_hit;

   assign req_ready = (state == S_IDLE);

   // In IDLE the aligner sees the live request; afterwards the latched copy.
   assign al_size   = (state == S_IDLE) ? req_size      : lat_size;
   assign al_lo     = (state == S_IDLE) ? req_addr[1:0] : lat_lo;
   assign al_signed = (state == S_IDLE) ? req_signed    : lat_signed;

   mips_bus_lane_align u_align (
      .size       (al_size),
      .lo         (al_lo),
      .sign_ext   (al_signed),
      .wdata      (req_wdata),
      .rdata_raw  (readdata),
      .byteenable (al_be),
      .writedata  (al_wdata),
      .rdata_fmt  (al_rdata),
      .misaligned (al_misaligned)
   );

`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n)
         stall_cnt <= '0;
      else if (state != S_BUS)
         stall_cnt <= '0;
      else if (waitrequest)
         stall_cnt <= stall_cnt + TO_W'(1);
   end

   assign timeout_hit = (state == S_BUS) && waitrequest &&
                        (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         lat_size   <= 2'b00;
         lat_lo     <= 2'b00;
         lat_signed <= 1'b0;
         address    <= 32'h0;
         read       <= 1'b0;
         write      <= 1'b0;
         byteenable <= 4'b0000;
         writedata  <= 32'h0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lat_size   <= req_size;
                  lat_lo     <= req_addr[1:0];
                  lat_signed <= req_signed;
                  if (al_misaligned) begin
                     state      <= S_RESP_ERR;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state      <= S_BUS;
                     address    <= {req_addr[31:2], 2'b00};
                     read       <= ~req_write;
                     write      <= req_write;
                     byteenable <= al_be;
                     writedata  <= al_wdata;
                  end
               end
            end
            S_BUS: begin
               if (!waitrequest) begin
                  read  <= 1'b0;
                  write <= 1'b0;
                  if (write) begin
                     resp_valid <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     state <= S_RDATA;
                  end
               end else if (timeout_hit) begin
                  read       <= 1'b0;
                  write      <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  state      <= S_RESP_ERR;
               end
            end
            S_RDATA: begin
               resp_valid <= 1'b1;
               resp_rdata <= al_rdata;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_bus_master.sv
// Directed self-checking bench for mips_bus_master with a small RAM responder.
module tb_mips_bus_master;
   import mips_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata = 32'h0;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [0:63];
   int          stall_left = 0;
   logic        stall_forever = 1'b0;

   logic [31:0] snap_addr;
   logic [3:0]  snap_be;
   logic [31:0] snap_wd;
   logic        snap_rd;
   logic        snap_wr;

   always #5 clk = ~clk;

   mips_bus_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .address    (address),
      .read       (read),
      .write      (write),
      .byteenable (byteenable),
      .writedata  (writedata),
      .waitrequest(waitrequest),
      .readdata   (readdata)
   );

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   assign waitrequest = (stall_left != 0) || stall_forever;

   // RAM responder: stalls for stall_left command edges, readdata lands a cycle later.
   always @(posedge clk) begin
      if (!reset_n)
         stall_left <= 0;
      else if ((read || write) && waitrequest && stall_left > 0)
         stall_left <= stall_left - 1;
      if (reset_n && read && !waitrequest)
         readdata <= mem[address[7:2]] & lane_mask(byteenable);
      if (reset_n && write && !waitrequest)
         mem[address[7:2]] <= (mem[address[7:2]] & ~lane_mask(byteenable)) |
                              (writedata & lane_mask(byteenable));
   end

   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_write  = ~wr;
      req_size   = 2'd3;
      req_signed = ~sg;
      req_addr   = 32'hDEADBEE3;
      req_wdata  = 32'h5555AAAA;
   endtask

   // Counts negedges after the acceptance edge until resp_valid; k = -1 on timeout.
   task automatic wait_resp(output int k, output logic rdy, output int cmd_cycles, output logic held);
      logic [69:0] first;
      logic [69:0] now;
      k = 0;
      rdy = 1'b0;
      cmd_cycles = 0;
      held = 1'b1;
      first = '0;
      repeat (60) begin
         @(negedge clk);
         k++;
         now = {address, byteenable, writedata, read, write};
         if (k == 1) begin
            first = now;
            snap_addr = address;
            snap_be = byteenable;
            snap_wd = writedata;
            snap_rd = read;
            snap_wr = write;
         end
         if (read || write) begin
            cmd_cycles++;
            if (now !== first) held = 1'b0;
         end
         if (resp_valid) begin
            rdy = req_ready;
            return;
         end
      end
      k = -1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({read, write, resp_valid, resp_err} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 0000", {read, write, resp_valid, resp_err});
      end
      checks++;
      if (address !== 32'h0 || byteenable !== 4'h0 || writedata !== 32'h0 || resp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_data: got addr=%h be=%b wd=%h rd=%h expected all zero",
                  address, byteenable, writedata, resp_rdata);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b expected 1", req_ready);
      end
   endtask

   task automatic test_word_load();
      int k, cc;
      logic rdy, held;
      mem[1] = 32'h12345678;
      stall_left = 0;
      issue(1'b0, SIZE_WORD, 1'b0, RAM_BASE + 32'h4, 32'h0);
      wait_resp(k, rdy, cc, held);
      checks++;
      if (snap_addr !== 32'hBFC00004 || snap_be !== 4'b1111 || snap_rd !== 1'b1 || snap_wr !== 1'b0) begin
         failures++;
         $display("FAIL word_load_cmd: got addr=%h be=%b rd=%b wr=%b expected bfc00004 1111 1 0",
                  snap_addr, snap_be, snap_rd, snap_wr);
      end
      checks++;
      if (k !== 3 || cc !== 1) begin
         failures++;
         $display("FAIL word_load_latency: got k=%0d cmd=%0d expected k=3 cmd=1", k, cc);
      end
      checks++;
      if (resp_rdata !== 32'h12345678 || resp_err !== 1'b0 || rdy !== 1'b1) begin
         failures++;
         $display("FAIL word_load_data: got %h err=%b rdy=%b expected 12345678 0 1", resp_rdata, resp_err, rdy);
      end
   endtask

   task automatic test_byte_load();
      int k, cc;
      logic rdy, held;
      logic [1:0]  szs [5] = '{SIZE_BYTE, SIZE_BYTE, SIZE_HALF, SIZE_HALF, SIZE_BYTE};
      logic        sgs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] ofs [5] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h0};
      logic [3:0]  bes [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0001};
      logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00000011, 32'h00000011};
      mem[0] = 32'h80FF0011;
      for (int i = 0; i < 5; i++) begin
         stall_left = i;
         issue(1'b0, szs[i], sgs[i], RAM_BASE + ofs[i], 32'h0);
         wait_resp(k, rdy, cc, held);
         checks++;
         if (snap_be !== bes[i] || k !== 3 + i || resp_rdata !== exp[i] || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL sub_load[%0d]: got be=%b k=%0d data=%h err=%b expected be=%b k=%0d data=%h err=0",
                     i, snap_be, k, resp_rdata, resp_err, bes[i], 3 + i, exp[i]);
         end
      end
   endtask

   task automatic test_stores();
      int k, cc;
      logic rdy, held;
      mem[4] = 32'h11112222;
      stall_left = 5;
      issue(1'b1, SIZE_HALF, 1'b0, RAM_BASE + 32'h12, 32'h0000BEEF);
      wait_resp(k, rdy, cc, held);
      checks++;
      if (snap_addr !== 32'hBFC00010 || snap_be !== 4'b1100 || snap_wd !== 32'hBEEFBEEF || snap_wr !== 1'b1) begin
         failures++;
         $display("FAIL half_store_cmd: got addr=%h be=%b wd=%h wr=%b expected bfc00010 1100 beefbeef 1",
                  snap_addr, snap_be, snap_wd, snap_wr);
      end
      checks++;
      if (held !== 1'b1 || cc !== 6 || k !== 7) begin
         failures++;
         $display("FAIL half_store_stall: got held=%b cmd=%0d k=%0d expected 1 6 7", held, cc, k);
      end
      checks++;
      if (mem[4] !== 32'hBEEF2222 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
         failures++;
         $display("FAIL half_store_ram: got mem=%h rd=%h err=%b expected beef2222 0 0", mem[4], resp_rdata, resp_err);
      end
      mem[5] = 32'h0;
      stall_left = 0;
      issue(1'b1, SIZE_BYTE, 1'b0, RAM_BASE + 32'h15, 32'h000001A5);
      wait_resp(k, rdy, cc, held);
      checks++;
      if (snap_be !== 4'b0010 || snap_wd !== 32'hA5A5A5A5 || k !== 2 || mem[5] !== 32'h0000A500) begin
         failures++;
         $display("FAIL byte_store: got be=%b wd=%h k=%0d mem=%h expected 0010 a5a5a5a5 2 0000a500",
                  snap_be, snap_wd, k, mem[5]);
      end
   endtask

   task automatic test_illegal();
      int k, cc;
      logic rdy, held;
      logic        wrs [3] = '{1'b0, 1'b0, 1'b1};
      logic [1:0]  szs [3] = '{SIZE_WORD, SIZE_HALF, 2'd3};
      logic [31:0] ofs [3] = '{32'h2, 32'h1, 32'h0};
      for (int i = 0; i < 3; i++) begin
         stall_left = 0;
         issue(wrs[i], szs[i], 1'b0, RAM_BASE + ofs[i], 32'hFFFFFFFF);
         wait_resp(k, rdy, cc, held);
         checks++;
         if (k !== 1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || cc !== 0) begin
            failures++;
            $display("FAIL illegal[%0d]: got k=%0d err=%b data=%h cmd=%0d expected k=1 err=1 data=0 cmd=0",
                     i, k, resp_err, resp_rdata, cc);
         end
      end
   endtask

   task automatic test_reset_in_bus();
      logic saw_resp;
      stall_left = 20;
      issue(1'b0, SIZE_WORD, 1'b0, RAM_BASE, 32'h0);
      @(negedge clk);
      checks++;
      if (read !== 1'b1) begin
         failures++;
         $display("FAIL rst_bus_pre: got read=%b expected 1", read);
      end
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if (read !== 1'b0 || write !== 1'b0 || resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_bus_drop: got rd=%b wr=%b rv=%b expected 0 0 0", read, write, resp_valid);
      end
      reset_n = 1'b1;
      saw_resp = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid) saw_resp = 1'b1;
      end
      checks++;
      if (saw_resp !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_bus_after: got resp_seen=%b ready=%b expected 0 1", saw_resp, req_ready);
      end
   endtask

   task automatic test_back_to_back();
      int k, cc;
      logic rdy, held;
      mem[8] = 32'h0;
      stall_left = 0;
      issue(1'b1, SIZE_WORD, 1'b0, RAM_BASE + 32'h20, 32'hCAFEF00D);
      wait_resp(k, rdy, cc, held);
      checks++;
      if (k !== 2 || rdy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_store: got k=%0d ready=%b expected 2 1", k, rdy);
      end
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_size   = SIZE_WORD;
      req_signed = 1'b0;
      req_addr   = RAM_BASE + 32'h20;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 32'hDEADBEE3;
      req_size  = 2'd3;
      wait_resp(k, rdy, cc, held);
      checks++;
      if (k !== 3 || resp_rdata !== 32'hCAFEF00D || resp_err !== 1'b0) begin
         failures++;
         $display("FAIL b2b_load: got k=%0d data=%h err=%b expected 3 cafef00d 0", k, resp_rdata, resp_err);
      end
   endtask

`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      int k, cc;
      logic rdy, held;
      stall_forever = 1'b1;
      issue(1'b0, SIZE_WORD, 1'b0, RAM_BASE, 32'h0);
      wait_resp(k, rdy, cc, held);
      stall_forever = 1'b0;
      checks++;
      if (cc !== 8 || k !== 9 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL timeout: got cmd=%0d k=%0d err=%b data=%h expected 8 9 1 0", cc, k, resp_err, resp_rdata);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      test_reset();
      test_word_load();
      test_byte_load();
      test_stores();
      test_illegal();
      test_reset_in_bus();
      test_back_to_back();
`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
